// File: rtl/window_addr_gen.sv
// window_addr_gen: KxK window address sweep over a scratchpad image.
// Optional window counter output enabled by defining WINDOW_AG_COUNT_EN.
module window_addr_gen #(
  parameter int ADDR_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_LENGTH = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reg_clear,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_o_size,
  input  logic [1:0]            i_stride,
  input  logic                  i_ready,
  output logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] o_addr,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done
`ifdef WINDOW_AG_COUNT_EN
  ,
  output logic [15:0]           o_win_count
`endif
);

  localparam int AW = ADDR_WIDTH;
  localparam int K  = KERNEL_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] isz;
  logic [AW-1:0] osz;
  logic [AW-1:0] step_c;
  logic [AW-1:0] step_r;
  logic [AW-1:0] row_base;
  logic [AW-1:0] col_base;
  logic [AW-1:0] r;
  logic [AW-1:0] c;
  logic [AW-1:0] osz_m1;
  logic [1:0]    s_in;
  logic [AW-1:0] step_r_in;
  logic [AW-1:0] koff [K];
  logic          start_ok;
  logic          consume;
  logic          last_c;
  logic          last_r;

  assign start_ok = (state == IDLE) & i_start;
  assign consume  = (state == GEN) & i_ready;
  assign osz_m1   = osz - AW'(1);
  assign last_c   = (c == osz_m1);
  assign last_r   = (r == osz_m1);

  // Stride 0 acts as 1; row step is stride*i_size built from shifts/adds.
  always_comb begin
    s_in      = (i_stride == 2'd0) ? 2'd1 : i_stride;
    step_r_in = i_i_size;
    unique case (1'b1)
      (s_in == 2'd3): step_r_in = i_i_size + (i_i_size << 1);
      (s_in == 2'd2): step_r_in = i_i_size << 1;
      default:        step_r_in = i_i_size;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state and status outputs; clear forces IDLE over everything.
  always_comb begin
    state_nx = state;
    o_valid  = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start)
          state_nx = (i_o_size == '0) ? DONE : GEN;
      end
      GEN: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready && last_c && last_r)
          state_nx = DONE;
      end
      DONE: begin
        o_busy   = 1'b1;
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (i_reg_clear) state_nx = IDLE;
  end

  // Latched config, window counters and incremental row/column bases.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      isz      <= '0;
      osz      <= '0;
      step_c   <= '0;
      step_r   <= '0;
      row_base <= '0;
      col_base <= '0;
      r        <= '0;
      c        <= '0;
    end else if (i_reg_clear) begin
      isz      <= '0;
      osz      <= '0;
      step_c   <= '0;
      step_r   <= '0;
      row_base <= '0;
      col_base <= '0;
      r        <= '0;
      c        <= '0;
    end else if (start_ok) begin
      isz      <= i_i_size;
      osz      <= i_o_size;
      step_c   <= AW'(s_in);
      step_r   <= step_r_in;
      row_base <= i_base_addr;
      col_base <= '0;
      r        <= '0;
      c        <= '0;
    end else if (consume) begin
      if (last_c) begin
        c        <= '0;
        col_base <= '0;
        if (!last_r) begin
          r        <= r + AW'(1);
          row_base <= row_base + step_r;
        end
      end else begin
        c        <= c + AW'(1);
        col_base <= col_base + step_c;
      end
    end
  end

  // Kernel row offsets kr*i_size as an adder chain.
  always_comb begin
    koff[0] = '0;
    for (int kr = 1; kr < K; kr++)
      koff[kr] = koff[kr-1] + isz;
  end

  // Window addresses, driven only while a window is presented.
  always_comb begin
    o_addr = '0;
    if (state == GEN) begin
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          o_addr[kr*K+kc] = row_base + koff[kr] + col_base + AW'(kc);
    end
  end

`ifdef WINDOW_AG_COUNT_EN
  // Consumed-window count for the current sweep.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)          o_win_count <= '0;
    else if (i_reg_clear) o_win_count <= '0;
    else if (start_ok)    o_win_count <= '0;
    else if (consume)     o_win_count <= o_win_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen: directed sweeps checked against a window model.
// Covers stride, wrap, stall, clear, reset and ignored restarts.
module tb_window_addr_gen;

  typedef logic [0:8][7:0] win_t;

  logic       clk;
  logic       i_nrst;
  logic       i_reg_clear;
  logic       i_start;
  logic [7:0] i_base_addr;
  logic [7:0] i_i_size;
  logic [7:0] i_o_size;
  logic [1:0] i_stride;
  logic       i_ready;
  win_t       o_addr;
  logic       o_valid;
  logic       o_busy;
  logic       o_done;
`ifdef WINDOW_AG_COUNT_EN
  logic [15:0] o_win_count;
`endif

  window_addr_gen dut (
    .i_clk       (clk),
    .i_nrst      (i_nrst),
    .i_reg_clear (i_reg_clear),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_i_size    (i_i_size),
    .i_o_size    (i_o_size),
    .i_stride    (i_stride),
    .i_ready     (i_ready),
    .o_addr      (o_addr),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
`ifdef WINDOW_AG_COUNT_EN
    ,
    .o_win_count (o_win_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  bit   done_pending = 1'b0;
  bit   ed;
  bit   ev;
  win_t exp_q [$];
  win_t win_log [$];
  win_t w;

  task automatic chk(string name, logic [71:0] got, logic [71:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic win_t model_win(int b, int isz, int s, int r, int c);
    win_t m;
    int   se;
    se = (s == 0) ? 1 : s;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        m[kr*3+kc] = 8'((b + (r*se + kr)*isz + c*se + kc) & 255);
    return m;
  endfunction

  // Per-cycle comparison against the expected window queue.
  always @(negedge clk) begin
    ed = done_pending;
    done_pending = 1'b0;
    ev = (exp_q.size() > 0);
    chk("valid", 72'(o_valid), 72'(ev));
    chk("done", 72'(o_done), 72'(ed));
    chk("busy", 72'(o_busy), 72'(ev | ed));
    if (ev && o_valid) begin
      chk("addr", o_addr, exp_q[0]);
      if (i_ready) begin
        win_log.push_back(o_addr);
        void'(exp_q.pop_front());
        n_pop++;
        if (exp_q.size() == 0) done_pending = 1'b1;
      end
    end
  end

  task automatic sweep(int b, int isz, int osz, int s);
    i_base_addr = 8'(b);
    i_i_size    = 8'(isz);
    i_o_size    = 8'(osz);
    i_stride    = 2'(s);
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    win_log.delete();
    n_pop = 0;
    for (int r = 0; r < osz; r++)
      for (int c = 0; c < osz; c++)
        exp_q.push_back(model_win(b, isz, s, r, c));
    if (osz == 0) done_pending = 1'b1;
    i_base_addr = 8'hA5;
    i_i_size    = 8'd9;
    i_o_size    = 8'd7;
    i_stride    = 2'd3;
  endtask

  task automatic wait_done(int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || done_pending) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("sweep_timeout", 72'(exp_q.size() == 0 && !done_pending), 72'd1);
    exp_q.delete();
    done_pending = 1'b0;
  endtask

  task automatic wait_pop(int n);
    int k;
    k = 0;
    while (n_pop < n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("pop_timeout", 72'(n_pop >= n), 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_nrst = 1'b0; i_reg_clear = 1'b0; i_start = 1'b0;
    i_base_addr = '0; i_i_size = '0; i_o_size = '0;
    i_stride = '0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", o_addr, 72'd0);
    chk("rst_flags", 72'({o_valid, o_busy, o_done}), 72'd0);
    i_nrst = 1'b1;
    @(posedge clk); #1;

    sweep(0, 5, 3, 1);
    wait_done(60);
    chk("s1_count", 72'(win_log.size()), 72'd9);
    chk("s1_w0", win_log[0], {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
    chk("s1_w1", win_log[1], {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13});
    chk("s1_w8", win_log[8], {8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd22, 8'd23, 8'd24});
`ifdef WINDOW_AG_COUNT_EN
    chk("s1_wcnt", 72'(o_win_count), 72'd9);
`endif

    sweep(0, 5, 2, 2);
    wait_done(40);
    chk("s2_count", 72'(win_log.size()), 72'd4);
    chk("s2_w01", win_log[1], {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14});
    w = win_log[2];
    chk("s2_w10_0", 72'(w[0]), 72'd10);

    sweep(0, 5, 3, 1);
    wait_pop(2);
    i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_ready = 1'b1;
    wait_done(60);
    chk("stall_count", 72'(win_log.size()), 72'd9);
    chk("stall_w2", win_log[2], {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14});

    sweep(250, 4, 1, 1);
    wait_done(20);
    chk("wrap_w0", win_log[0], {8'd250, 8'd251, 8'd252, 8'd254, 8'd255, 8'd0, 8'd2, 8'd3, 8'd4});

    sweep(0, 5, 2, 0);
    wait_done(40);
    chk("s0_w01", win_log[1], {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13});

    sweep(7, 6, 2, 3);
    wait_pop(1);
    i_start = 1'b1; i_base_addr = 8'd99; i_o_size = 8'd5; i_stride = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_done(40);
    chk("busy_start_count", 72'(win_log.size()), 72'd4);

    sweep(0, 5, 0, 1);
    wait_done(10);
    chk("osz0_count", 72'(win_log.size()), 72'd0);
`ifdef WINDOW_AG_COUNT_EN
    chk("osz0_wcnt", 72'(o_win_count), 72'd0);
`endif

    sweep(0, 5, 3, 1);
    wait_pop(4);
    i_ready = 1'b0; i_reg_clear = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_reg_clear = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    exp_q.delete();
    done_pending = 1'b0;
    @(posedge clk); #1;
    chk("clr_count", 72'(win_log.size()), 72'd4);
`ifdef WINDOW_AG_COUNT_EN
    chk("clr_wcnt", 72'(o_win_count), 72'd0);
`endif
    sweep(0, 5, 3, 1);
    wait_done(60);
    chk("clr_restart_w0", win_log[0], {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
    chk("clr_restart_cnt", 72'(win_log.size()), 72'd9);

    sweep(3, 5, 3, 1);
    wait_pop(3);
    i_nrst = 1'b0;
    #1;
    exp_q.delete();
    done_pending = 1'b0;
    chk("arst_addr", o_addr, 72'd0);
    chk("arst_flags", 72'({o_valid, o_busy, o_done}), 72'd0);
    @(posedge clk); #1;
    i_nrst = 1'b1;
    @(posedge clk); #1;
    sweep(3, 5, 3, 1);
    wait_done(60);
    chk("arst_restart_w0", win_log[0], {8'd3, 8'd4, 8'd5, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15});
    chk("arst_restart_cnt", 72'(win_log.size()), 72'd9);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 Param ADDR_WIDTH, default 8, sets the width of one spad address.
REQ-002 Param KERNEL_SIZE, default 3, sets the kernel side length.
REQ-003 Param ADDR_LENGTH, default KERNEL_SIZE*KERNEL_SIZE, sets the number of addresses per window.
REQ-004 Port i_clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 Port i_nrst, input, 1 bit: asynchronous active-low reset.
REQ-006 Port i_reg_clear, input, 1 bit: synchronous clear.
REQ-007 Port i_start, input, 1 bit: start a window sweep.
REQ-008 Port i_base_addr, input, ADDR_WIDTH: address of input pixel (0,0).
REQ-009 Port i_i_size, input, ADDR_WIDTH: input row width in pixels.
REQ-010 Port i_o_size, input, ADDR_WIDTH: output rows and columns (square).
REQ-011 Port i_stride, input, 2 bits: window stride (1..3).
REQ-012 Port i_ready, input, 1 bit: downstream MPP FIFO can accept (not full).
REQ-013 Port o_addr, output, [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]: window addresses, index kr*KERNEL_SIZE+kc.
REQ-014 Port o_valid, output, 1 bit: o_addr holds a window; drives the MPP write enable when ANDed with i_ready.
REQ-015 Port o_busy, output, 1 bit: FSM not IDLE.
REQ-016 Port o_done, output, 1 bit: one-cycle pulse at sweep end.

Function
REQ-017 FSM states SHALL be IDLE, GEN and DONE.
REQ-018 In IDLE, i_start SHALL latch i_base_addr, i_i_size, i_o_size and i_stride; next state GEN, or DONE if i_o_size==0.
REQ-019 In GEN, o_valid SHALL be 1 and o_addr[kr*K+kc] SHALL be base + (r*stride+kr)*i_size + c*stride + kc, truncated modulo 2^ADDR_WIDTH.
REQ-020 The first window SHALL appear in the cycle after the start edge, i.e. one-cycle latency.
REQ-021 A window SHALL be consumed only when o_valid & i_ready; otherwise o_addr and the counters SHALL hold.
REQ-022 On consume, c SHALL increment; at c==o_size-1, c SHALL wrap to 0 and r SHALL increment.
REQ-023 Consuming window (o_size-1, o_size-1) SHALL move the FSM to DONE.
REQ-024 DONE SHALL last one cycle with o_done=1 and o_valid=0, then return to IDLE.
REQ-025 Address terms SHALL be kept as incremental row-base and column-base registers, with no multiplier in the per-window path.
REQ-026 i_start outside IDLE SHALL be ignored; input changes after latching SHALL have no effect.
REQ-027 i_stride==0 SHALL be treated as 1.
REQ-028 o_busy SHALL be 1 in GEN and DONE.

Reset
REQ-029 i_nrst low SHALL asynchronously force IDLE, zero the counters and latched config, and set o_addr=0, o_valid=0, o_busy=0, o_done=0.
REQ-030 i_reg_clear SHALL do the same synchronously, overriding i_start in the same cycle, and SHALL abort a sweep in progress with no o_done.

Configuration
REQ-031 With macro WINDOW_AG_COUNT_EN defined, an output o_win_count [15:0] SHALL exist; it is zeroed on reset, on clear and at each accepted start, and increments per consumed window.
REQ-032 Without WINDOW_AG_COUNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 base=0, i_size=5, o_size=3, stride=1, i_ready=1 -> window0 addresses 0,1,2,5,6,7,10,11,12; window1 addresses 1,2,3,6,7,8,11,12,13; window8 addresses 12,13,14,17,18,19,22,23,24; o_done one cycle after window8.
REQ-034 base=0, i_size=5, o_size=2, stride=2 -> window(0,1) addresses 2,3,4,7,8,9,12,13,14; window(1,0) starts at 10; 4 windows total.
REQ-035 i_ready low for 3 cycles during window2 -> o_addr and o_valid held steady; window2 is written exactly once; total window count is unchanged.
REQ-036 base=250, i_size=4, o_size=1 -> addresses 250,251,252,254,255,0,2,3,4 (wrap-around).
REQ-037 i_reg_clear during window4, or i_nrst mid-sweep -> next cycle IDLE, o_valid=0, no o_done; a new i_start restarts at window0.
REQ-038 o_size=0, or i_start while busy -> o_done after one cycle with no o_valid; the restart attempt is ignored; o_win_count matches the consumed windows when WINDOW_AG_COUNT_EN is defined.
